// File: rtl/alu_bist_driver.sv
`timescale 1ns/1ps
// alu_bist_driver: issues ROM patterns to the alu one at a time and checks each o_valid response.
// Define ALU_BIST_GAP_EN to insert LFSR-timed idle gaps before every issue.
module alu_bist_driver #(
    parameter int INT_W   = 7,
    parameter int FRAC_W  = 5,
    parameter int INST_W  = 3,
    parameter int DATA_W  = INT_W + FRAC_W,
    parameter int PAT_NUM = 20,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 1024,
    parameter int ERR_W   = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    output logic [ADDR_W-1:0]          o_pat_addr,
    input  logic [2*DATA_W+INST_W-1:0] i_pat_in,
    input  logic [DATA_W:0]            i_pat_exp,
    output logic                       o_alu_valid,
    output logic [DATA_W-1:0]          o_alu_data_a,
    output logic [DATA_W-1:0]          o_alu_data_b,
    output logic [INST_W-1:0]          o_alu_inst,
    input  logic                       i_alu_valid,
    input  logic [DATA_W-1:0]          i_alu_data,
    input  logic                       i_alu_overflow,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_pass,
    output logic [ERR_W-1:0]           o_err_cnt,
    output logic                       o_timeout,
    output logic                       o_spurious
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAT_NUM - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [2:0]        w_fetch_nx;
    logic [2:0]        w_gap_nx;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W:0]   r_exp;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [INST_W-1:0] r_inst;
    logic [CNT_W-1:0]  r_tcnt;
    logic [ERR_W-1:0]  r_err_cnt;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;
    logic              r_spurious;
    logic              w_start;
    logic              w_issue;
    logic              w_wait;
    logic              w_resp;
    logic              w_expire;
    logic              w_last;
    logic              w_mismatch;
    logic              w_err;

    assign w_start    = (r_state == S_IDLE) && i_start;
    assign w_issue    = r_state == S_ISSUE;
    assign w_wait     = r_state == S_WAIT;
    assign w_resp     = w_wait && i_alu_valid;
    assign w_expire   = w_wait && !i_alu_valid && (r_tcnt == TO_LAST);
    assign w_last     = r_addr == LAST_ADDR;
    // Result data is don't-care whenever overflow is expected.
    assign w_mismatch = (i_alu_overflow != r_exp[DATA_W]) ||
                        (!r_exp[DATA_W] && (i_alu_data != r_exp[DATA_W-1:0]));
    assign w_err      = (w_resp && w_mismatch) || w_expire;

`ifdef ALU_BIST_GAP_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_lfsr <= 8'hA5;
        else
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end

    assign w_fetch_nx = S_GAP;
    assign w_gap_nx   = r_lfsr[0] ? S_ISSUE : S_GAP;
`else
    assign w_fetch_nx = S_ISSUE;
    assign w_gap_nx   = S_ISSUE;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_start ? S_FETCH : S_IDLE;
            S_FETCH: w_next = w_fetch_nx;
            S_GAP:   w_next = w_gap_nx;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = (w_resp || w_expire) ? S_NEXT : S_WAIT;
            S_NEXT:  w_next = w_last ? S_IDLE : S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_exp      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_inst     <= '0;
            r_tcnt     <= '0;
            r_err_cnt  <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_NEXT) && w_last;
            if (w_start) begin
                r_addr    <= '0;
                r_err_cnt <= '0;
                r_pass    <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (r_state == S_NEXT) begin
                if (w_last)
                    r_pass <= r_err_cnt == '0;
                else
                    r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_issue) begin
                r_a    <= i_pat_in[DATA_W-1:0];
                r_b    <= i_pat_in[2*DATA_W-1:DATA_W];
                r_inst <= i_pat_in[2*DATA_W+INST_W-1:2*DATA_W];
                r_exp  <= i_pat_exp;
            end
            r_tcnt <= w_issue ? '0 : (w_wait ? r_tcnt + CNT_W'(1) : r_tcnt);
            if (w_err && (r_err_cnt != ERR_MAX))
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            if (w_expire)
                r_timeout <= 1'b1;
            r_spurious <= (i_alu_valid && !w_wait) || (r_spurious && !w_start);
        end
    end

    // Operands come straight from the ROM on the issue cycle and are held afterwards.
    assign o_alu_valid  = w_issue;
    assign o_alu_data_a = w_issue ? i_pat_in[DATA_W-1:0] : r_a;
    assign o_alu_data_b = w_issue ? i_pat_in[2*DATA_W-1:DATA_W] : r_b;
    assign o_alu_inst   = w_issue ? i_pat_in[2*DATA_W+INST_W-1:2*DATA_W] : r_inst;
    assign o_pat_addr   = r_addr;
    assign o_busy       = r_state != S_IDLE;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_cnt    = r_err_cnt;
    assign o_timeout    = r_timeout;
    assign o_spurious   = r_spurious;
endmodule
